// File: rtl/muldiv_seq.sv
// muldiv_seq: step sequencer for the shared multi-cycle mul/div unit in EXE.
// Drives step strobes, the IF/ID stall and the one-cycle completion pulse.
module muldiv_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       is_div_i,
  input  logic [1:0] op_i,
  input  logic       div_special_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic [1:0] mul_state_o,
  output logic       d_init_o,
  output logic       d_advance_o,
  output logic       div_last_o,
  output logic       special_o,
  output logic [2:0] op_q_o,
  output logic       fin_o
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_INIT,
    DIV_ITER,
    DIV_LAST,
    DONE
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [3:0] cnt;
  logic [3:0] cnt_d;
  logic [2:0] op_q;
  logic [2:0] op_d;
  logic       spc_q;
  logic       spc_d;
  logic       accept;
  logic       busy;

  assign accept = (state == IDLE) & start_i & ~flush_i;

  assign busy = (state == MUL)
              | (state == DIV_INIT)
              | (state == DIV_ITER)
              | (state == DIV_LAST);

  // State, step counter and accepted-operation registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_q  <= 3'd0;
      spc_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      spc_q <= spc_d;
    end
  end

  // Next-state and counter update; a flush overrides everything.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    spc_d   = spc_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_d  = {is_div_i, op_i};
          spc_d = is_div_i & div_special_i;
          cnt_d = 4'd0;
          if (!is_div_i)
            state_d = MUL;
          else if (div_special_i)
            state_d = DONE;
          else
            state_d = DIV_INIT;
        end
      end
      MUL: begin
        if (cnt == 4'd3) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      DIV_INIT: state_d = DIV_ITER;
      DIV_ITER: begin
        cnt_d = cnt + 4'd1;
        if (cnt == 4'd15)
          state_d = DIV_LAST;
      end
      DIV_LAST: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  assign stall_o     = ~reset & (accept | busy);
  assign mul_state_o = (state == MUL) ? cnt[1:0] : 2'd0;
  assign d_init_o    = (state == DIV_INIT);
  assign d_advance_o = (state == DIV_ITER);
  assign div_last_o  = (state == DIV_LAST);
  assign fin_o       = (state == DONE);
  assign special_o   = (state == DONE) & spc_q;
  assign op_q_o      = op_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed cycle-by-cycle checks of the mul/div sequencer.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic       is_div_i;
  logic [1:0] op_i;
  logic       div_special_i;
  logic       flush_i;
  logic       stall_o;
  logic [1:0] mul_state_o;
  logic       d_init_o;
  logic       d_advance_o;
  logic       div_last_o;
  logic       special_o;
  logic [2:0] op_q_o;
  logic       fin_o;

  int n_err = 0;
  int n_chk = 0;

  muldiv_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .is_div_i      (is_div_i),
    .op_i          (op_i),
    .div_special_i (div_special_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .mul_state_o   (mul_state_o),
    .d_init_o      (d_init_o),
    .d_advance_o   (d_advance_o),
    .div_last_o    (div_last_o),
    .special_o     (special_o),
    .op_q_o        (op_q_o),
    .fin_o         (fin_o)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {stall_o, mul_state_o, d_init_o, d_advance_o,
                div_last_o, special_o, op_q_o, fin_o};

  function automatic logic [10:0] ev(
    input logic       st,
    input logic [1:0] ms,
    input logic       di,
    input logic       da,
    input logic       dl,
    input logic       sp,
    input logic [2:0] op,
    input logic       fin
  );
    return {st, ms, di, da, dl, sp, op, fin};
  endfunction

  task automatic check(
    input string       tag,
    input logic [10:0] got,
    input logic [10:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [10:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    start_i       = 1'b1;
    is_div_i      = 1'b0;
    op_i          = 2'b00;
    div_special_i = 1'b0;
    flush_i       = 1'b0;

    look("rst_a", 11'd0);
    tick();
    look("rst_b", 11'd0);
    tick();
    reset   = 1'b0;
    start_i = 1'b0;
    look("idle0", 11'd0);
    tick();

    // mulh: op 11
    start_i  = 1'b1;
    is_div_i = 1'b0;
    op_i     = 2'b11;
    look("mul_c0", ev(1, 0, 0, 0, 0, 0, 3'b000, 0));
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      look($sformatf("mul_c%0d", c),
           ev(1, 2'(c - 1), 0, 0, 0, 0, 3'b011, 0));
      tick();
    end
    look("mul_fin", ev(0, 0, 0, 0, 0, 0, 3'b011, 1));
    tick();
    look("mul_idle", ev(0, 0, 0, 0, 0, 0, 3'b011, 0));
    tick();

    // div: op 00, normal
    start_i       = 1'b1;
    is_div_i      = 1'b1;
    op_i          = 2'b00;
    div_special_i = 1'b0;
    look("div_c0", ev(1, 0, 0, 0, 0, 0, 3'b011, 0));
    tick();
    start_i = 1'b0;
    look("div_init", ev(1, 0, 1, 0, 0, 0, 3'b100, 0));
    tick();
    for (int c = 2; c <= 17; c++) begin
      look($sformatf("div_it%0d", c),
           ev(1, 0, 0, 1, 0, 0, 3'b100, 0));
      tick();
    end
    look("div_last", ev(1, 0, 0, 0, 1, 0, 3'b100, 0));
    tick();
    look("div_fin", ev(0, 0, 0, 0, 0, 0, 3'b100, 1));
    tick();
    look("div_idle", ev(0, 0, 0, 0, 0, 0, 3'b100, 0));
    tick();

    // divu by zero: special path
    start_i       = 1'b1;
    is_div_i      = 1'b1;
    op_i          = 2'b01;
    div_special_i = 1'b1;
    look("spc_c0", ev(1, 0, 0, 0, 0, 0, 3'b100, 0));
    tick();
    start_i       = 1'b0;
    div_special_i = 1'b0;
    look("spc_fin", ev(0, 0, 0, 0, 0, 1, 3'b101, 1));
    tick();
    look("spc_idle", ev(0, 0, 0, 0, 0, 0, 3'b101, 0));
    tick();

    // rem flushed in cycle 8, then mul from cycle 9
    start_i  = 1'b1;
    is_div_i = 1'b1;
    op_i     = 2'b10;
    look("fl_c0", ev(1, 0, 0, 0, 0, 0, 3'b101, 0));
    tick();
    start_i = 1'b0;
    look("fl_init", ev(1, 0, 1, 0, 0, 0, 3'b110, 0));
    tick();
    for (int c = 2; c <= 7; c++) begin
      look($sformatf("fl_it%0d", c),
           ev(1, 0, 0, 1, 0, 0, 3'b110, 0));
      tick();
    end
    flush_i = 1'b1;
    look("fl_c8", ev(1, 0, 0, 1, 0, 0, 3'b110, 0));
    tick();
    flush_i  = 1'b0;
    start_i  = 1'b1;
    is_div_i = 1'b0;
    op_i     = 2'b00;
    look("fl_c9", ev(1, 0, 0, 0, 0, 0, 3'b110, 0));
    tick();
    start_i = 1'b0;
    for (int c = 10; c <= 13; c++) begin
      look($sformatf("fl_mul%0d", c),
           ev(1, 2'(c - 10), 0, 0, 0, 0, 3'b000, 0));
      tick();
    end
    look("fl_fin14", ev(0, 0, 0, 0, 0, 0, 3'b000, 1));
    tick();

    // flush beats start in IDLE
    start_i  = 1'b1;
    flush_i  = 1'b1;
    is_div_i = 1'b0;
    op_i     = 2'b01;
    look("fp_c0", ev(0, 0, 0, 0, 0, 0, 3'b000, 0));
    tick();
    start_i = 1'b0;
    flush_i = 1'b0;
    look("fp_c1", ev(0, 0, 0, 0, 0, 0, 3'b000, 0));
    tick();

    // back-to-back mulhu with start held
    start_i  = 1'b1;
    is_div_i = 1'b0;
    op_i     = 2'b10;
    look("bb_c0", ev(1, 0, 0, 0, 0, 0, 3'b000, 0));
    tick();
    for (int c = 1; c <= 4; c++) begin
      look($sformatf("bb_a%0d", c),
           ev(1, 2'(c - 1), 0, 0, 0, 0, 3'b010, 0));
      tick();
    end
    look("bb_fin5", ev(0, 0, 0, 0, 0, 0, 3'b010, 1));
    tick();
    look("bb_acc6", ev(1, 0, 0, 0, 0, 0, 3'b010, 0));
    tick();
    start_i = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      look($sformatf("bb_b%0d", c),
           ev(1, 2'(c - 7), 0, 0, 0, 0, 3'b010, 0));
      tick();
    end
    look("bb_fin11", ev(0, 0, 0, 0, 0, 0, 3'b010, 1));
    tick();
    look("bb_idle", ev(0, 0, 0, 0, 0, 0, 3'b010, 0));
    tick();

    // remu aborted by reset during the iterations
    start_i       = 1'b1;
    is_div_i      = 1'b1;
    op_i          = 2'b11;
    div_special_i = 1'b0;
    look("rs_c0", ev(1, 0, 0, 0, 0, 0, 3'b010, 0));
    tick();
    start_i = 1'b0;
    look("rs_init", ev(1, 0, 1, 0, 0, 0, 3'b111, 0));
    tick();
    for (int c = 2; c <= 4; c++) begin
      look($sformatf("rs_it%0d", c),
           ev(1, 0, 0, 1, 0, 0, 3'b111, 0));
      tick();
    end
    reset   = 1'b1;
    start_i = 1'b1;
    look("rs_async", 11'd0);
    tick();
    reset   = 1'b0;
    start_i = 1'b0;
    look("rs_rel", 11'd0);
    tick();
    look("rs_idle", 11'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Purpose: sequences the shared multi-cycle multiplier/divider datapath in EXE. The block generates the step controls, the pipeline stall and the completion pulse, and replaces the ad-hoc mul/div counters in the decode stage.

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start_i  in  1  decoded M-extension instruction present in ID and ID enabled.
REQ-004 is_div_i  in  1  1 = div/divu/rem/remu; 0 = mul/mulh/mulhsu/mulhu.
REQ-005 op_i  in  2  variant within class (00 lo/div, 01 hsu/divu, 10 hu/rem, 11 h/remu).
REQ-006 div_special_i  in  1  divisor==0 or signed overflow (INT_MIN / -1); sampled with start_i.
REQ-007 flush_i  in  1  pipeline flush from hazard unit.
REQ-008 stall_o  out  1  hold IF/ID while the operation is in flight.
REQ-009 mul_state_o  out  2  multiplier step index.
REQ-010 d_init_o  out  1  divider load-operands strobe.
REQ-011 d_advance_o  out  1  divider iteration strobe.
REQ-012 div_last_o  out  1  divider final-correction strobe.
REQ-013 special_o  out  1  select architecturally defined special result instead of datapath output.
REQ-014 op_q_o  out  3  latched {is_div, op} of the accepted operation.
REQ-015 fin_o  out  1  one-cycle completion pulse; result valid this cycle.

Function
REQ-016 The block SHALL implement states IDLE, MUL, DIV_INIT, DIV_ITER, DIV_LAST and DONE, with a 4-bit step counter cnt.
REQ-017 In IDLE, when start_i=1 and flush_i=0, the block SHALL accept the operation, latch op_q_o={is_div_i,op_i}, clear cnt, and transition as follows:
- is_div_i=0 -> MUL
- is_div_i=1 and div_special_i=1 -> DONE
- is_div_i=1 and div_special_i=0 -> DIV_INIT
REQ-018 MUL SHALL last exactly 4 cycles with mul_state_o=cnt[1:0] taking values 0,1,2,3; after cnt=3 it SHALL go to DONE.
REQ-019 DIV_INIT SHALL last 1 cycle with d_init_o=1, then go to DIV_ITER.
REQ-020 DIV_ITER SHALL last exactly 16 cycles with d_advance_o=1 and cnt=0..15; cnt wraps 15->0 on exit to DIV_LAST.
REQ-021 DIV_LAST SHALL last 1 cycle with div_last_o=1, then go to DONE.
REQ-022 DONE SHALL last 1 cycle with fin_o=1, then go to IDLE; special_o=1 in DONE only for an operation accepted via the special path.
REQ-023 Latency from the acceptance edge to fin_o: mul 5 cycles, normal div 19 cycles, special div 1 cycle.
REQ-024 stall_o SHALL equal (IDLE & start_i & ~flush_i) | state in {MUL, DIV_INIT, DIV_ITER, DIV_LAST}; stall_o SHALL be 0 in DONE so the instruction advances with its result.
REQ-025 start_i SHALL be ignored in every state except IDLE; in particular, start_i in DONE is not accepted and is only taken in the following IDLE cycle.
REQ-026 When flush_i=1 in any state, the next state SHALL be IDLE, cnt SHALL clear, and no fin_o SHALL be produced for the aborted operation; flush_i has priority over start_i.
REQ-027 d_init_o, d_advance_o, div_last_o and fin_o SHALL be mutually exclusive and SHALL be 0 in IDLE.
REQ-028 All outputs SHALL be registered-state decodes; there is no combinational path from any input to any output except stall_o.
REQ-029 op_q_o SHALL remain stable from acceptance through DONE.

Reset
REQ-030 While reset=1, the block SHALL be in state IDLE with cnt=0 and op_q_o=0.
REQ-031 While reset=1, all other outputs SHALL be 0, including stall_o regardless of start_i.
REQ-032 Reset asserted mid-operation SHALL abort the operation immediately, with no fin_o produced.

Verification
REQ-033 mul: start_i=1, is_div_i=0, op_i=11 at cycle 0 -> mul_state_o=0,1,2,3 in cycles 1-4; fin_o=1 in cycle 5 only; stall_o=1 in cycles 0-4 and 0 in cycle 5.
REQ-034 div: start_i=1, is_div_i=1, div_special_i=0 -> d_init_o in cycle 1; d_advance_o in cycles 2-17; div_last_o in cycle 18; fin_o in cycle 19; op_q_o=100 throughout.
REQ-035 divide by zero: start_i=1, is_div_i=1, div_special_i=1 -> fin_o=1 and special_o=1 in cycle 1; stall_o=1 in cycle 0 only.
REQ-036 flush: flush_i=1 in cycle 8 of a div -> IDLE in cycle 9; no fin_o ever; a new mul started in cycle 9 completes with fin_o in cycle 14.
REQ-037 back-to-back: start_i held high across a mul -> second operation accepted in cycle 6 (IDLE after DONE) with fin_o in cycle 11; start_i at the DONE cycle is ignored.
REQ-038 reset: assert reset during DIV_ITER -> stall_o=0 and all strobes=0 asynchronously; after release the block sits in IDLE.
